div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 30 +++
 rtl/div_intf.sv | 41 ++++
 rtl/div_step.sv | 30 +++
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the iterative divider.
//   div_op_t : operation select (DIV, DIVU, REM, REMU)
//   state_t  : control FSM states
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Signed operations interpret operands as two's complement.
  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  // Quotient-producing operations; the others return the remainder.
  function automatic logic op_is_quot(input div_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/div_intf.sv
// div_intf: request/response bundle of div_unit.
//   request : in_valid, in_ready, div_op, in_a (dividend), in_b (divisor)
//   response: out_valid, out_ready, result, zero
//   modports: master (requester), slave (div_unit), cov and asrt (observe only)
interface div_intf
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  div_op_t          div_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, div_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, div_op, in_a, in_b, out_ready,
    output in_ready, out_valid, result, zero
  );

  modport cov (
    input in_valid, in_ready, div_op, in_a, in_b,
          out_valid, out_ready, result, zero
  );

  modport asrt (
    input in_valid, in_ready, div_op, in_a, in_b,
          out_valid, out_ready, result, zero
  );

endinterface

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step (purely combinational).
//   rem_i : partial remainder      dvd_i : remaining dividend bits (MSB next)
//   dvs_i : divisor magnitude
//   rem_o : next partial remainder quo_o : dividend bits shifted, new quotient bit in LSB
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] trial_s;

  // Shift in the next dividend bit and trial-subtract; the extra top bit is the borrow.
  always_comb begin
    shifted_s = {rem_i, dvd_i[WIDTH-1]};
    trial_s   = {1'b0, shifted_s} - {2'b00, dvs_i};
    if (trial_s[WIDTH+1]) begin
      rem_o = shifted_s[WIDTH-1:0];
    end else begin
      rem_o = trial_s[WIDTH-1:0];
    end
    quo_o = {dvd_i[WIDTH-2:0], ~trial_s[WIDTH+1]};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per clock.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : div_intf slave (request in, result out)
// Divide-by-zero and signed overflow complete on the accept edge; all other
// requests take WIDTH CALC edges plus one FIX edge for sign correction.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_intf.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZEROS   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  div_op_t          op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;

  logic [WIDTH-1:0] rem_nx_s, quo_nx_s;
  logic [WIDTH-1:0] q_fix_s, r_fix_s;
  logic             sgn_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx_s),
    .quo_o (quo_nx_s)
  );

  // Next-state, datapath and result computation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    sgn_s    = op_is_signed(bus.div_op);
    q_fix_s  = (a_neg_q ^ b_neg_q) ? (ZEROS - quo_q) : quo_q;
    r_fix_s  = a_neg_q ? (ZEROS - rem_q) : rem_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.div_op;
          if (bus.in_b == ZEROS) begin
            state_d  = DONE;
            result_d = op_is_quot(bus.div_op) ? ONES : bus.in_a;
          end else if (sgn_s && (bus.in_a == MOST_NEG) && (bus.in_b == ONES)) begin
            state_d  = DONE;
            result_d = (bus.div_op == DIV) ? bus.in_a : ZEROS;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH);
            a_neg_d = sgn_s & bus.in_a[WIDTH-1];
            b_neg_d = sgn_s & bus.in_b[WIDTH-1];
            // quo_q starts as the dividend magnitude and is shifted into the quotient.
            quo_d   = (sgn_s & bus.in_a[WIDTH-1]) ? (ZEROS - bus.in_a) : bus.in_a;
            dvs_d   = (sgn_s & bus.in_b[WIDTH-1]) ? (ZEROS - bus.in_b) : bus.in_b;
            rem_d   = ZEROS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = rem_nx_s;
        quo_d = quo_nx_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        result_d = op_is_quot(op_q) ? q_fix_s : r_fix_s;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d  = IDLE;
          result_d = ZEROS;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d  = IDLE;
        result_d = ZEROS;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= DIV;
      cnt_q    <= {CW{1'b0}};
      rem_q    <= ZEROS;
      quo_q    <= ZEROS;
      dvs_q    <= ZEROS;
      result_q <= ZEROS;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = ~|result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (WIDTH = 32) with directed and
// random requests checked against an arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_intf #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed/unsigned arithmetic plus the special-case rules.
  function automatic logic [31:0] ref_res(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (op)
      DIV:  if (b == 32'd0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return 32'(sa / sb);
      DIVU: if (b == 32'd0) return 32'hFFFF_FFFF; else return a / b;
      REM:  if (b == 32'd0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return 32'(sa % sb);
      default: if (b == 32'd0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 0;
    if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return W + 1;
  endfunction

  // Issue one request, wait for the result, then hand it off with out_ready.
  // lat = number of edges after the accept edge before out_valid is seen.
  task automatic do_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat, output bit ok);
    int n;
    ok = 1'b1;
    n  = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.div_op   = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) ok = 1'b0;
    res = bus.result;
    z   = bus.zero;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%0b want=1", bus.zero); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    div_op_t     ops [7] = '{DIV, DIV, REM, DIVU, REMU, DIV, REM};
    logic [31:0] as  [7] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [7] = '{32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exs [7] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          els [7] = '{33, 33, 33, 0, 0, 0, 0};
    logic [31:0] res;
    logic        z;
    int          lat;
    bit          ok;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i], res, z, lat, ok);
      total++; if (!ok) begin bad++; $display("FAIL dir%0d_timeout got=no out_valid want=out_valid", i); end
      total++; if (res !== exs[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, exs[i]); end
      total++; if (lat !== els[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, els[i]); end
      total++; if (z !== (exs[i] == 32'd0)) begin bad++; $display("FAIL dir%0d_zero got=%0b want=%0b", i, z, exs[i] == 32'd0); end
    end
  endtask

  task automatic test_random;
    div_op_t     op;
    logic [31:0] a, b, res, ex;
    logic        z;
    int          lat, el;
    bit          ok;
    for (int i = 0; i < 40; i++) begin
      op = div_op_t'($urandom_range(0, 3));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = 32'(-$urandom_range(1, 15));
        4: a = 32'h8000_0000;
        default: a = a;
      endcase
      ex = ref_res(op, a, b);
      el = ref_lat(op, a, b);
      do_op(op, a, b, res, z, lat, ok);
      total++; if (!ok || res !== ex) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, ex); end
      total++; if (lat !== el) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, el); end
      total++; if (z !== (ex == 32'd0)) begin bad++; $display("FAIL rnd%0d_zero got=%0b want=%0b", i, z, ex == 32'd0); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.div_op   = DIVU;
    bus.in_a     = 32'd1000;
    bus.in_b     = 32'd7;
    @(posedge clk);
    #1;
    // Keep presenting a different request while the first one is in flight.
    bus.in_a = 32'd55;
    bus.in_b = 32'd5;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (!bus.out_valid) begin bad++; $display("FAIL bp_timeout got=no out_valid want=out_valid"); end
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.result !== 32'd142) begin bad++; $display("FAIL bp_result_c%0d got=%h want=%h", i, bus.result, 32'd142); end
      total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_handshake_c%0d got=rdy%0b/vld%0b want=rdy0/vld1", i, bus.in_ready, bus.out_valid); end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin bad++; $display("FAIL bp_release got=rdy%0b/vld%0b/res%h want=rdy1/vld0/res0", bus.in_ready, bus.out_valid, bus.result); end
  endtask

  task automatic test_reset_mid_calc;
    logic [31:0] res;
    logic        z;
    int          lat;
    bit          ok;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.div_op   = DIV;
    bus.in_a     = 32'd12345;
    bus.in_b     = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%0b want=1", bus.in_ready); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rstmid_zero got=%0b want=1", bus.zero); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) begin
        total++; bad++;
        $display("FAIL rstmid_ghost got=out_valid1 want=out_valid0 cycle=%0d", i);
        break;
      end
    end
    do_op(DIVU, 32'd100, 32'd10, res, z, lat, ok);
    total++; if (!ok || res !== 32'd10) begin bad++; $display("FAIL rstmid_followup got=%h want=%h", res, 32'd10); end
    total++; if (lat !== W + 1) begin bad++; $display("FAIL rstmid_latency got=%0d want=%0d", lat, W + 1); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res1, res2;
    logic        z;
    int          lat;
    bit          ok;
    // do_op returns #1 after the handshake edge, so the unit must already be idle.
    do_op(REMU, 32'd17, 32'd0, res1, z, lat, ok);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%0b want=1", bus.in_ready); end
    do_op(REM, 32'hFFFF_FFF9, 32'd0, res2, z, lat, ok);
    total++; if (res1 !== 32'd17 || res2 !== 32'hFFFF_FFF9) begin bad++; $display("FAIL b2b_results got=%h/%h want=%h/%h", res1, res2, 32'd17, 32'hFFFF_FFF9); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    bus.in_valid  = 1'b0;
    bus.div_op    = DIV;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
